mod_add_sub_258: RTL



---
 rtl/mod_add_sub_258.sv | 93 +++++++++
 1 files changed

// File: rtl/mod_add_sub_258.sv
// Sequential modular adder/subtractor: (a +/- b) mod p over a single shared
// WIDTH+1 bit adder used once for the raw sum and once for the correction.
module mod_add_sub_258 #(
  parameter int WIDTH = 258
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             out_wrap
);

  typedef enum logic [1:0] {IDLE, CALC, CORR, DONE} state_t;

  state_t           state, state_nxt;
  logic             op_r;
  logic [WIDTH-1:0] a_r, b_r, p_r;
  logic [WIDTH:0]   t_r;

  logic [WIDTH:0]   add_x, add_y;
  logic             add_ci;
  logic [WIDTH+1:0] add_s;
  logic             wrap_c;
  logic [WIDTH-1:0] res_c;

  // Shared adder: CALC forms a +/- b, CORR forms t -/+ p. Subtraction is
  // x + ~y + 1; the extra carry bit in CORR/ADD is set exactly when t >= p.
  always_comb begin
    add_x  = {1'b0, a_r};
    add_y  = op_r ? ~{1'b0, b_r} : {1'b0, b_r};
    add_ci = op_r;
    if (state == CORR) begin
      add_x  = t_r;
      add_y  = op_r ? {1'b0, p_r} : ~{1'b0, p_r};
      add_ci = ~op_r;
    end
  end

  assign add_s  = {1'b0, add_x} + {1'b0, add_y} + {{(WIDTH+1){1'b0}}, add_ci};
  assign wrap_c = op_r ? t_r[WIDTH] : add_s[WIDTH+1];
  assign res_c  = wrap_c ? add_s[WIDTH-1:0] : t_r[WIDTH-1:0];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = CALC;
      CALC:    state_nxt = CORR;
      CORR:    state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_r     <= 1'b0;
      a_r      <= '0;
      b_r      <= '0;
      p_r      <= '0;
      t_r      <= '0;
      result   <= '0;
      out_wrap <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (in_valid) begin
          op_r <= op_sub;
          a_r  <= a;
          b_r  <= b;
          p_r  <= p;
        end
        CALC: t_r <= add_s[WIDTH:0];
        CORR: begin
          result   <= res_c;
          out_wrap <= wrap_c;
        end
        default: ;
      endcase
    end
  end

endmodule
